f2d_pipe_reg: RTL and testbench

- Parametrised fetch-to-decode pipeline register; next generation of the plain F/D latch.
- Adds valid/ready handshake, a 2-entry skid buffer so `in_ready` is a registered output, synchronous flush for branch/jump squash, and NOP injection when empty.
- Sits between fetch and decode. Carries instruction, incremented PC and fetch error.

---
 rtl/f2d_pipe_reg_pkg.sv | 13 +
 rtl/f2d_pipe_reg_if.sv | 27 ++
 rtl/f2d_pipe_reg_pipe_entry.sv | 27 ++
 rtl/f2d_pipe_reg.sv | 142 ++++++++++++++
 tb/tb_f2d_pipe_reg.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/f2d_pipe_reg_pkg.sv
// Shared definitions for the WISC pipeline registers: entry-state encoding and
// the NOP word injected by any pipe register that has nothing valid to present.
package wisc_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } pipe_state_e;

    localparam logic [15:0] PIPE_NOP_INSTR = 16'h0800;

endpackage

// File: rtl/f2d_pipe_reg_if.sv
// Fetch-to-decode handshake bundle: the master side is fetch/decode,
// the slave side is the pipeline register itself.
interface f2d_pipe_reg_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_in;
    logic               err_in;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic               err_out;

    modport master (
        output in_valid, instr_in, pc_in, err_in, out_ready,
        input  in_ready, out_valid, instr_out, pc_out, err_out
    );

    modport slave (
        input  in_valid, instr_in, pc_in, err_in, out_ready,
        output in_ready, out_valid, instr_out, pc_out, err_out
    );
endinterface

// File: rtl/f2d_pipe_reg_pipe_entry.sv
// Width-parametrised storage entry with load enable; used for both the main
// (output-driving) entry and the skid entry of the pipe register.
module pipe_entry #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Entry storage: captures d_i when load_i is high, reset value on rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= RST_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/f2d_pipe_reg.sv
// Fetch-to-decode pipeline register with valid/ready handshake, 2-entry skid
// buffer, flush and NOP injection. Optional stall counter: F2D_STALL_CNT_EN.
module f2d_pipe_reg
    import wisc_pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    f2d_pipe_reg_if.slave      bus
`ifdef F2D_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    localparam int ENT_W = INSTR_W + PC_W + 1;
    localparam logic [ENT_W-1:0] MAIN_RST = {NOP_INSTR, {PC_W{1'b0}}, 1'b0};

    pipe_state_e      state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic             accept_s, consume_s;
    logic             main_load_s, skid_load_s;
    logic [ENT_W-1:0] main_d, main_q, skid_q;
    logic [ENT_W-1:0] in_ent_s, empty_ent_s;

    assign accept_s    = bus.in_valid & in_ready_q;
    assign consume_s   = out_valid_q & bus.out_ready;
    assign in_ent_s    = {bus.instr_in, bus.pc_in, bus.err_in};
    // An empty main entry shows NOP with no error but keeps the last PC.
    assign empty_ent_s = {NOP_INSTR, main_q[PC_W:1], 1'b0};

    pipe_entry #(.W(ENT_W), .RST_VAL(MAIN_RST)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load_i (main_load_s),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_entry #(.W(ENT_W), .RST_VAL({ENT_W{1'b0}})) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load_s),
        .d_i    (in_ent_s),
        .q_o    (skid_q)
    );

    // Next-state and entry-load decode; flush overrides every other event.
    always_comb begin
        state_d     = state_q;
        main_load_s = 1'b0;
        skid_load_s = 1'b0;
        main_d      = in_ent_s;
        if (flush) begin
            state_d     = EMPTY;
            main_load_s = 1'b1;
            main_d      = empty_ent_s;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        state_d     = ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && consume_s) begin
                        main_load_s = 1'b1;
                    end else if (accept_s) begin
                        state_d     = TWO;
                        skid_load_s = 1'b1;
                    end else if (consume_s) begin
                        state_d     = EMPTY;
                        main_load_s = 1'b1;
                        main_d      = empty_ent_s;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (consume_s) begin
                        state_d     = ONE;
                        main_load_s = 1'b1;
                        main_d      = skid_q;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_load_s = 1'b1;
                    main_d      = empty_ent_s;
                end
            endcase
        end
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.instr_out = main_q[ENT_W-1 -: INSTR_W];
    assign bus.pc_out    = main_q[PC_W:1];
    assign bus.err_out   = main_q[0];

`ifdef F2D_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles where decode holds off a valid entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= {CNT_W{1'b0}};
        end else if (out_valid_q && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_q;
`else
    logic [CNT_W-1:0] unused_cnt_s;
    assign unused_cnt_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_f2d_pipe_reg.sv
// Self-checking bench for f2d_pipe_reg: directed steps then random traffic,
// checked against a queue-based model of a 2-deep FIFO register.
module tb_f2d_pipe_reg;

    localparam int IW = 16;
    localparam int PW = 16;
    localparam int CW = 4;
    localparam logic [15:0] NOP = 16'h0800;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    f2d_pipe_reg_if #(.INSTR_W(IW), .PC_W(PW)) bus ();

`ifdef F2D_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    f2d_pipe_reg #(
        .INSTR_W   (IW),
        .PC_W      (PW),
        .NOP_INSTR (16'h0800),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
`ifdef F2D_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        err;
    } ent_t;

    ent_t        mq[$];
    logic        m_in_ready = 1'b1;
    logic [15:0] m_last_pc = 16'h0000;
    int unsigned m_stall = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        logic        ev;
        logic [15:0] ei;
        logic        ee;
        ev = (mq.size() > 0);
        ei = ev ? mq[0].instr : NOP;
        ee = ev ? mq[0].err : 1'b0;
        chk({ctx, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
        chk({ctx, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, m_in_ready});
        chk({ctx, ".instr_out"}, {16'd0, bus.instr_out}, {16'd0, ei});
        chk({ctx, ".pc_out"},    {16'd0, bus.pc_out},    {16'd0, m_last_pc});
        chk({ctx, ".err_out"},   {31'd0, bus.err_out},   {31'd0, ee});
`ifdef F2D_STALL_CNT_EN
        chk({ctx, ".stall_cnt"}, {28'd0, stall_cnt}, m_stall);
`endif
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic e, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.instr_in  = ins;
        bus.pc_in     = pc;
        bus.err_in    = e;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic tick(input string ctx);
        logic had_valid;
        logic acc;
        logic con;
        ent_t e;
        @(posedge clk);
        had_valid = (mq.size() > 0);
        acc = bus.in_valid & m_in_ready;
        con = had_valid & bus.out_ready;
        if (had_valid && !bus.out_ready && m_stall < (2 ** CW) - 1) m_stall++;
        if (flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) begin
                e.instr = bus.instr_in;
                e.pc    = bus.pc_in;
                e.err   = bus.err_in;
                mq.push_back(e);
            end
        end
        m_in_ready = (mq.size() < 2);
        if (mq.size() > 0) m_last_pc = mq[0].pc;
        #1;
        check_outputs(ctx);
    endtask

    initial begin
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single transfer with 1-cycle latency
        drive(1'b1, 16'h4123, 16'h0002, 1'b0, 1'b1, 1'b0);
        tick("single");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick("single_drain");

        // Backpressure to full, then drain in order
        drive(1'b1, 16'hA001, 16'h0004, 1'b0, 1'b0, 1'b0);
        tick("bp_push1");
        drive(1'b1, 16'hA002, 16'h0006, 1'b0, 1'b0, 1'b0);
        tick("bp_push2");
        drive(1'b1, 16'hA003, 16'h0008, 1'b0, 1'b0, 1'b0);
        tick("bp_full_hold");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick("bp_drain1");
        tick("bp_drain2");
        tick("bp_empty");

        // Flush while full with a simultaneous offer that must be dropped
        drive(1'b1, 16'hC001, 16'h0010, 1'b0, 1'b0, 1'b0);
        tick("fl_push1");
        drive(1'b1, 16'hC002, 16'h0012, 1'b0, 1'b0, 1'b0);
        tick("fl_push2");
        drive(1'b1, 16'hBEEF, 16'h0014, 1'b0, 1'b1, 1'b1);
        tick("flush");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick("post_flush");
        chk("no_beef", {31'd0, (bus.instr_out == 16'hBEEF)}, 32'd0);

        // Error entry held while stalled, cleared once drained
        drive(1'b1, 16'h1234, 16'h0016, 1'b1, 1'b0, 1'b0);
        tick("err_push");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick("err_hold1");
        tick("err_hold2");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick("err_drain");

        // Asynchronous reset between edges while full
        drive(1'b1, 16'hD001, 16'h0020, 1'b0, 1'b0, 1'b0);
        tick("ar_push1");
        drive(1'b1, 16'hD002, 16'h0022, 1'b1, 1'b0, 1'b0);
        tick("ar_push2");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        m_in_ready = 1'b1;
        m_last_pc  = 16'h0000;
        m_stall    = 0;
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // Long stall: counter (when present) must saturate
        drive(1'b1, 16'hE001, 16'h0030, 1'b0, 1'b0, 1'b0);
        tick("stall_push");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick("stall_hold");
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick("stall_flush");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
